cordic_rotator: RTL and testbench
=================================

# cordic_rotator

Iterative rotation-mode CORDIC engine for the CORDIC project. It computes one micro-rotation per clock and is sequenced by the external iteration counter: the block drives that counter's opcode and terminal value, and consumes its address and terminal flag. It also holds the x/y/z datapath registers and the arctangent table. It sits between the host/top-level handshake and the counter, and produces scaled cos/sin results.

## Interface
- `W`, 16: datapath width; signed two's complement, Q2.14 (14 fraction bits).
- `N`, 4: counter width; must match the counter's `n`.
- `ITER`, 16: iteration count. Requires ITER ≤ 2^N and ITER ≤ W.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  start request; sampled only in IDLE.
- `x_i`, `y_i`, `z_i`  in  W  initial vector and angle in radians, |z_i| ≤ π/2.
- `ready_o`  out  1  high in IDLE.
- `done_o`  out  1  one-cycle pulse; results valid.
- `x_o`, `y_o`, `z_o`  out  W  result registers, held until the next start.
- `cnt_opc_o`  out  2  counter opcode: 0 = clear, 1 = hold, 2 = increment.
- `cnt_n_o`  out  N  constant ITER-1.
- `cnt_addr_i`  in  N  iteration index i from the counter.
- `cnt_z_i`  in  1  counter terminal flag (addr == ITER-1).

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset values:
  - state IDLE.
  - x/y/z registers 0.
  - `done_o` 0, `ready_o` 1.
  - `cnt_opc_o` 0.
- IDLE:
  - `cnt_opc_o` = 0, which keeps the counter at 0.
  - When `start_i` = 1: load x, y, z from the inputs, then go to RUN.
- RUN, once per cycle, with i = `cnt_addr_i`:
  - d = +1 if z ≥ 0, else −1.
  - x ← x − d·(y >>> i)
  - y ← y + d·(x >>> i)
  - z ← z − d·atan(2^-i)
  - `>>>` is an arithmetic shift; low bits are truncated.
  - All three updates use the pre-update values, and all add/subtract results wrap modulo 2^W (no saturation).
  - `cnt_opc_o` = 2 while `cnt_z_i` = 0.
  - When `cnt_z_i` = 1: perform the last micro-rotation, drive `cnt_opc_o` = 0, go to DONE.
- DONE:
  - `done_o` = 1, `cnt_opc_o` = 0.
  - Next state is always IDLE.
- Results:
  - `x_o`/`y_o`/`z_o` come directly from the datapath registers.
  - No gain compensation: outputs are scaled by K ≈ 1.6468. The caller pre-scales x_i by 1/K (0.60725 = 9949 in Q2.14).
- `start_i` in RUN or DONE is ignored and not queued.
- `cnt_z_i` is ignored outside RUN.
- Reset mid-operation: immediate return to IDLE with the reset values above; the counter is cleared by its own reset or by opc 0.

## Timing
- Edge E0 samples `start_i` = 1 in IDLE; inputs are loaded at E0.
- Micro-rotations occur at edges E1 through E_ITER, with i = 0 … ITER-1. The counter increments on the same edges, so `cnt_addr_i` = k−1 during the cycle before E_k.
- `done_o` is high for exactly the cycle between E_ITER and E_ITER+1; outputs are final from E_ITER.
- `ready_o` is high again after E_ITER+1.
  - Start-to-start minimum is ITER+2 cycles (18 for defaults).
  - A start asserted during the done cycle is lost.
- No combinational path from any input to any output except constant `cnt_n_o`.

## Structure
Package `cordic_pkg`:
- State enum (IDLE, RUN, DONE).
- Opcode constants CNT_CLR = 0, CNT_HOLD = 1, CNT_INC = 2.
- Q2.14 arctangent table, rounded to nearest, for i = 0..15: 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0.

Sub-modules:
- `cordic_atan_rom`: combinational, indexed by `cnt_addr_i`, returns the W-bit table entry.
- The counter stays external and is instantiated beside this block at the top level.

## Test plan
- z_i = 0, x_i = 9949, y_i = 0 → `done_o` exactly 16 cycles after the start edge; x_o = 16384 ±8, y_o = 0 ±8, z_o within ±4.
- z_i = 12868 (π/4), x_i = 9949, y_i = 0 → x_o = y_o = 11585 ±8.
- z_i = −12868 → x_o = 11585 ±8, y_o = −11585 ±8.
- Counter handshake: `cnt_opc_o` = 0 in IDLE; 2 for cycles E0..E15 with `cnt_addr_i` stepping 0..15; 0 in DONE; `done_o` one cycle wide; `cnt_n_o` = 15.
- `start_i` pulsed mid-RUN with different inputs → ignored, results match the first operation; a second start in the cycle after `done_o` (ready_o = 1) runs normally.
- `rst_i` asserted at E8 → immediately ready_o = 1, done_o = 0, x_o/y_o/z_o = 0, `cnt_opc_o` = 0; a subsequent start produces correct results.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC rotator.
//   cordic_state_e : sequencing states of the rotator FSM
//   CNT_*          : opcodes understood by the external iteration counter
//   atan_q14()     : atan(2^-i) in Q2.14, rounded to nearest, 0 beyond i = 15
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_e;

  localparam logic [1:0] CNT_CLR  = 2'd0;
  localparam logic [1:0] CNT_HOLD = 2'd1;
  localparam logic [1:0] CNT_INC  = 2'd2;

  function automatic int atan_q14(input int i);
    int v;
    case (i)
      0:       v = 12868;
      1:       v = 7596;
      2:       v = 4014;
      3:       v = 2037;
      4:       v = 1023;
      5:       v = 512;
      6:       v = 256;
      7:       v = 128;
      8:       v = 64;
      9:       v = 32;
      10:      v = 16;
      11:      v = 8;
      12:      v = 4;
      13:      v = 2;
      14:      v = 1;
      default: v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table lookup.
//   addr  : iteration index i
//   value : atan(2^-i) in Q2.14, W bits
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic [N-1:0] addr,
  output logic [W-1:0] value
);

  always_comb begin
    value = W'(atan_q14(int'(addr)));
  end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, sequenced by
// an external iteration counter. Outputs are scaled by K ~= 1.6468 (no gain
// compensation).
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   start_i / ready_o     : start request, accepted when both are high (IDLE)
//   x_i, y_i, z_i         : initial vector and angle (Q2.14)
//   done_o                : one-cycle pulse, results valid
//   x_o, y_o, z_o         : result registers, held until the next start
//   cnt_opc_o, cnt_n_o    : counter opcode and terminal value (ITER-1)
//   cnt_addr_i, cnt_z_i   : counter index and terminal flag
//   state_o               : current FSM state, for observation
//
// Handshake: start_i is a request and ready_o its acceptance; a start
// transfers on a rising edge where start_i && ready_o. Requests while
// ready_o is low are dropped, never queued. done_o carries no back-pressure.
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int W    = 16,
  parameter int N    = 4,
  parameter int ITER = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic signed [W-1:0] z_i,
  output logic                ready_o,
  output logic                done_o,
  output logic signed [W-1:0] x_o,
  output logic signed [W-1:0] y_o,
  output logic signed [W-1:0] z_o,
  output logic [1:0]          cnt_opc_o,
  output logic [N-1:0]        cnt_n_o,
  input  logic [N-1:0]        cnt_addr_i,
  input  logic                cnt_z_i,
  output logic [1:0]          state_o
);

  // Index of the second-to-last micro-rotation; seeing it means the next
  // cycle is the terminal one, so the counter must be told to clear.
  localparam logic [N-1:0] PEN_IDX = N'((ITER >= 2) ? ITER - 2 : 0);

  cordic_state_e       state_q, state_d;
  logic signed [W-1:0] x_q, y_q, z_q;
  logic [1:0]          opc_q, opc_d;

  logic [W-1:0]        atan_val;
  logic signed [W-1:0] x_sh, y_sh;
  logic signed [W-1:0] x_rot, y_rot, z_rot;

  cordic_atan_rom #(
    .W (W),
    .N (N)
  ) u_atan_rom (
    .addr  (cnt_addr_i),
    .value (atan_val)
  );

  // Micro-rotation; all terms use pre-update values and wrap modulo 2^W.
  always_comb begin
    x_sh = x_q >>> cnt_addr_i;
    y_sh = y_q >>> cnt_addr_i;
    if (z_q[W-1]) begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + signed'(atan_val);
    end else begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - signed'(atan_val);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      opc_q   <= CNT_CLR;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // The opcode is registered so that no input reaches an output
  // combinationally; it is computed one cycle ahead from the counter index.
  always_comb begin
    state_d = state_q;
    opc_d   = CNT_CLR;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          opc_d   = (ITER > 1) ? CNT_INC : CNT_CLR;
        end
      end
      ST_RUN: begin
        if (cnt_z_i) begin
          state_d = ST_DONE;
        end else if ((ITER >= 2) && (cnt_addr_i == PEN_IDX)) begin
          opc_d = CNT_CLR;
        end else begin
          opc_d = CNT_INC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      x_q <= x_i;
      y_q <= y_i;
      z_q <= z_i;
    end else if (state_q == ST_RUN) begin
      x_q <= x_rot;
      y_q <= y_rot;
      z_q <= z_rot;
    end
  end

  assign ready_o   = (state_q == ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign x_o       = x_q;
  assign y_o       = y_q;
  assign z_o       = z_q;
  assign cnt_opc_o = opc_q;
  assign cnt_n_o   = N'(ITER - 1);
  assign state_o   = state_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator: external counter model, directed
// known-angle cases, mid-run start, reset mid-run, randomized back-to-back ops.
module tb_cordic_rotator;

  localparam int W    = 16;
  localparam int N    = 4;
  localparam int ITER = 16;
  localparam int ATAN [16] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128,
                               64, 32, 16, 8, 4, 2, 1, 0};

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic                start_i = 1'b0;
  logic signed [W-1:0] x_i = '0, y_i = '0, z_i = '0;
  logic                ready_o, done_o;
  logic signed [W-1:0] x_o, y_o, z_o;
  logic [1:0]          cnt_opc_o;
  logic [N-1:0]        cnt_n_o;
  logic [N-1:0]        cnt_addr;
  logic                cnt_z;
  logic [1:0]          state_o;

  cordic_rotator #(.W(W), .N(N), .ITER(ITER)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .x_i        (x_i),
    .y_i        (y_i),
    .z_i        (z_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .x_o        (x_o),
    .y_o        (y_o),
    .z_o        (z_o),
    .cnt_opc_o  (cnt_opc_o),
    .cnt_n_o    (cnt_n_o),
    .cnt_addr_i (cnt_addr),
    .cnt_z_i    (cnt_z),
    .state_o    (state_o)
  );

  // External iteration counter: 0 clear, 1 hold, 2 increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_addr <= '0;
    else if (cnt_opc_o == 2'd0) cnt_addr <= '0;
    else if (cnt_opc_o == 2'd2) cnt_addr <= cnt_addr + 1'b1;
  end
  assign cnt_z = (cnt_addr == cnt_n_o);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [3*W-1:0] exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: ITER rotations with plain wrapped 16-bit arithmetic.
  function automatic logic [3*W-1:0] ref_rotate(input int xs, input int ys, input int zs);
    logic signed [W-1:0] x, y, z, xn, yn, xsh, ysh;
    x = W'(xs); y = W'(ys); z = W'(zs);
    for (int i = 0; i < ITER; i++) begin
      xsh = x >>> i;
      ysh = y >>> i;
      if (z >= 0) begin
        xn = x - ysh; yn = y + xsh; z = W'(int'(z) - ATAN[i]);
      end else begin
        xn = x + ysh; yn = y - xsh; z = W'(int'(z) + ATAN[i]);
      end
      x = xn; y = yn;
    end
    return {x, y, z};
  endfunction

  function automatic int rnd_s(input int mag);
    return int'($urandom_range(0, 2 * mag)) - mag;
  endfunction

  // ---------------- driver ----------------
  // glitch_k > 0 : pulse start with other inputs during RUN cycle glitch_k.
  // rst_k > 0    : assert reset right after edge E<rst_k> and stop.
  task automatic run_op(input int xs, input int ys, input int zs,
                        input int glitch_k, input int rst_k);
    int budget;
    int k;
    bit got;
    logic [3*W-1:0] e;
    budget = 0;
    while (!ready_o && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    check("ready_before_start", int'(ready_o), 1);
    x_i = W'(xs); y_i = W'(ys); z_i = W'(zs);
    start_i = 1'b1;
    if (rst_k == 0) exp_q.push_back(ref_rotate(xs, ys, zs));
    @(posedge clk_i);
    #1 start_i = 1'b0;

    if (rst_k > 0) begin
      repeat (rst_k) @(posedge clk_i);
      #1 rst_i = 1'b1;
      #1;
      check("rst_ready", int'(ready_o), 1);
      check("rst_done", int'(done_o), 0);
      check("rst_x", int'(x_o), 0);
      check("rst_y", int'(y_o), 0);
      check("rst_z", int'(z_o), 0);
      check("rst_opc", int'(cnt_opc_o), 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      return;
    end

    k = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      @(negedge clk_i);
      k++;
      if (k == glitch_k + 1 && glitch_k > 0) start_i = 1'b0;
      if (done_o) begin
        got = 1'b1;
      end else if (k <= ITER) begin
        check("run_opc", int'(cnt_opc_o), (k < ITER) ? 2 : 0);
        check("run_addr", int'(cnt_addr), k - 1);
        check("run_ready", int'(ready_o), 0);
        if (k == glitch_k) begin
          x_i = W'(rnd_s(9000)); y_i = W'(rnd_s(9000)); z_i = W'(rnd_s(20000));
          start_i = 1'b1;
        end
      end
    end
    start_i = 1'b0;
    check("done_seen", int'(got), 1);
    e = exp_q.pop_front();
    if (got) begin
      check("done_latency", k - 1, ITER);
      check("done_opc", int'(cnt_opc_o), 0);
      check("res_x", int'(x_o), int'(signed'(e[3*W-1:2*W])));
      check("res_y", int'(y_o), int'(signed'(e[2*W-1:W])));
      check("res_z", int'(z_o), int'(signed'(e[W-1:0])));
      @(negedge clk_i);
      check("done_width", int'(done_o), 0);
      check("ready_after", int'(ready_o), 1);
      check("idle_opc", int'(cnt_opc_o), 0);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    repeat (3) @(negedge clk_i);
    check("reset_ready", int'(ready_o), 1);
    check("reset_done", int'(done_o), 0);
    check("reset_state", int'(state_o), 0);
    check("reset_x", int'(x_o), 0);
    check("reset_y", int'(y_o), 0);
    check("reset_z", int'(z_o), 0);
    check("reset_opc", int'(cnt_opc_o), 0);
    check("cnt_n", int'(cnt_n_o), ITER - 1);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_opc_start", int'(cnt_opc_o), 0);

    run_op(9949, 0, 0, 0, 0);
    check("cos0_x_tol", int'(iabs(int'(x_o) - 16384) <= 8), 1);
    check("cos0_y_tol", int'(iabs(int'(y_o)) <= 8), 1);
    check("cos0_z_tol", int'(iabs(int'(z_o)) <= 4), 1);

    run_op(9949, 0, 12868, 0, 0);
    check("pi4_x_tol", int'(iabs(int'(x_o) - 11585) <= 8), 1);
    check("pi4_y_tol", int'(iabs(int'(y_o) - 11585) <= 8), 1);

    run_op(9949, 0, -12868, 0, 0);
    check("mpi4_x_tol", int'(iabs(int'(x_o) - 11585) <= 8), 1);
    check("mpi4_y_tol", int'(iabs(int'(y_o) + 11585) <= 8), 1);

    // Start pulsed mid-run is ignored; next start follows done immediately.
    run_op(9949, 0, 6000, 5, 0);
    run_op(rnd_s(9949), rnd_s(9949), rnd_s(25736), 0, 0);

    // Reset just after E8, then a normal operation.
    run_op(9949, 0, 12868, 0, 8);
    run_op(9949, 0, 12868, 0, 0);
    check("post_rst_x_tol", int'(iabs(int'(x_o) - 11585) <= 8), 1);

    for (int j = 0; j < 20; j++) begin
      run_op(rnd_s(9949), rnd_s(9949), rnd_s(25736), (j % 4 == 0) ? int'($urandom_range(1, ITER)) : 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
